// File: rtl/pdp8l_iot_master.sv
// IOT bus initiator: takes one opcode/AC transaction from the CPU side, runs the
// iopstart / settle / sample / iopstop handshake on the device bus, returns AC and skip.
module pdp8l_iot_master #(
  parameter int SETTLE = 4,
  parameter int RELTMO = 255
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        CSTEP,
  input  logic        req,
  input  logic [11:0] opcode,
  input  logic [11:0] ac_in,
  output logic        ack,
  output logic [11:0] ac_out,
  output logic        skip,
  output logic        busy,
  output logic        timeout,
  output logic        iopstart,
  output logic        iopstop,
  output logic [11:0] ioopcode,
  output logic [11:0] cputodev,
  input  logic [11:0] devtocpu,
  input  logic        AC_CLEAR,
  input  logic        IO_SKIP
);

  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, STOP} state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [7:0] RELTMO_L  = 8'(RELTMO);

  state_t     state, state_n;
  logic [3:0] cnt;
  logic [7:0] tmo;
  logic       accept, capture, load_cnt, dec_cnt, load_tmo, dec_tmo, set_timeout;
  logic       bus_idle;

  // Devices OR their data onto the bus; AC_CLEAR drops our own AC from the merge.
  function automatic logic [11:0] merge_ac(input logic clr, input logic [11:0] ac,
                                           input logic [11:0] dev);
    return (clr ? 12'o0000 : ac) | dev;
  endfunction

  assign bus_idle = (devtocpu == 12'o0000) && !AC_CLEAR && !IO_SKIP;

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    capture     = 1'b0;
    load_cnt    = 1'b0;
    dec_cnt     = 1'b0;
    load_tmo    = 1'b0;
    dec_tmo     = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE: if (req) begin
        accept  = 1'b1;
        state_n = START;
      end
      START: if (CSTEP) begin
        load_cnt = 1'b1;
        state_n  = WAIT;
      end
      WAIT: if (CSTEP) begin
        if (cnt == 4'd0) begin
          capture = 1'b1;
          state_n = DONE;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      DONE: begin
        load_tmo = 1'b1;
        state_n  = STOP;
      end
      STOP: if (CSTEP) begin
        if (bus_idle) begin
          state_n = IDLE;
        end else if (tmo == 8'd0) begin
          set_timeout = 1'b1;
          state_n     = IDLE;
        end else begin
          dec_tmo = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      tmo      <= 8'd0;
      ac_out   <= 12'o0000;
      skip     <= 1'b0;
      timeout  <= 1'b0;
      ioopcode <= 12'o0000;
      cputodev <= 12'o0000;
    end else begin
      state <= state_n;
      if (accept) begin
        ioopcode <= opcode;
        cputodev <= ac_in;
        timeout  <= 1'b0;
      end
      if (load_cnt) cnt <= SETTLE_M1;
      else if (dec_cnt) cnt <= cnt - 4'd1;
      if (capture) begin
        ac_out <= merge_ac(AC_CLEAR, cputodev, devtocpu);
        skip   <= IO_SKIP;
      end
      if (load_tmo) tmo <= RELTMO_L;
      else if (dec_tmo) tmo <= tmo - 8'd1;
      if (set_timeout) timeout <= 1'b1;
    end
  end

  assign iopstart = (state == START);
  assign iopstop  = (state == STOP);
  assign ack      = (state == DONE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_pdp8l_iot_master.sv
// Bench for pdp8l_iot_master: a behavioural device responder on the bus, a vector
// table of directed transactions, random transactions, and multi-cycle corner cases.
module tb_pdp8l_iot_master;
  localparam int SETTLE = 4;
  localparam int RELTMO = 255;

  logic        CLOCK, RESET, CSTEP, req;
  logic [11:0] opcode, ac_in;
  logic        ack, skip, busy, timeout, iopstart, iopstop;
  logic [11:0] ac_out, ioopcode, cputodev;
  logic [11:0] devtocpu = 12'o0000;
  logic        AC_CLEAR = 1'b0, IO_SKIP = 1'b0;

  pdp8l_iot_master #(.SETTLE(SETTLE), .RELTMO(RELTMO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .CSTEP(CSTEP), .req(req), .opcode(opcode),
    .ac_in(ac_in), .ack(ack), .ac_out(ac_out), .skip(skip), .busy(busy),
    .timeout(timeout), .iopstart(iopstart), .iopstop(iopstop), .ioopcode(ioopcode),
    .cputodev(cputodev), .devtocpu(devtocpu), .AC_CLEAR(AC_CLEAR), .IO_SKIP(IO_SKIP)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int vectors = 0;
  int miscompares = 0;
  int ack_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Device responder: joins the transaction on the iopstart CSTEP edge, drops its
  // response on the iopstop CSTEP edge. 'stuck' models a device that never lets go.
  logic        cfg_clr = 1'b0, cfg_skp = 1'b0, stuck = 1'b0, active = 1'b0;
  logic [11:0] cfg_data = 12'o0000, seen_op = 12'o0000, seen_ac = 12'o0000;

  always @(posedge CLOCK) begin
    logic st, sp, rs;
    logic [11:0] op_s, ac_s;
    st = iopstart && CSTEP;
    sp = iopstop && CSTEP;
    rs = RESET;
    op_s = ioopcode;
    ac_s = cputodev;
    #1;
    if (rs) active = 1'b0;
    else if (st) begin
      active  = 1'b1;
      seen_op = op_s;
      seen_ac = ac_s;
    end else if (sp) active = 1'b0;
    devtocpu = stuck ? 12'o0001 : (active ? cfg_data : 12'o0000);
    AC_CLEAR = active && cfg_clr;
    IO_SKIP  = active && cfg_skp;
  end

  always @(negedge CLOCK) begin
    if (!RESET) begin
      if (ack) ack_count++;
      if (busy) check("strobe_exclusive", 32'(iopstart & iopstop), 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic logic pick_cstep(input int period, input int j);
    if (period == 0) return ($urandom_range(0, 2) != 0);
    return ((j % period) == (period - 1));
  endfunction

  logic [11:0] last_op = 12'o0000;

  task automatic run_txn(input logic [11:0] op, input logic [11:0] ac, input logic clr,
                         input logic [11:0] data, input logic skp, input int period,
                         output logic [11:0] r_ac, output logic r_skip, output int k,
                         output int ncs, output int nstart, output int nstop,
                         output int nstop_cs);
    int j;
    logic cs, was_busy, was_stop, got, first;
    cfg_clr = clr; cfg_data = data; cfg_skp = skp;
    opcode = op; ac_in = ac; req = 1'b1; last_op = op;
    k = 0; ncs = 0; nstart = 0; nstop = 0; nstop_cs = 0; got = 1'b0;
    r_ac = 12'o0000; r_skip = 1'b0; j = 0;
    while (!got && j < 2000) begin
      CSTEP = pick_cstep(period, j);
      cs = CSTEP; was_busy = busy;
      tick(); j++;
      if (was_busy && cs) ncs++;
      if (iopstart) nstart++;
      if (ack) begin
        got = 1'b1; k = j; r_ac = ac_out; r_skip = skip;
        check("strobes_in_done", 32'({iopstart, iopstop}), 32'd0);
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    req = 1'b0;
    first = 1'b1;
    while (busy && j < 4000) begin
      CSTEP = pick_cstep(period, j);
      cs = CSTEP; was_stop = iopstop;
      tick(); j++;
      if (first) check("ack_one_cycle", 32'(ack), 32'd0);
      first = 1'b0;
      if (was_stop && cs) nstop_cs++;
      if (iopstop) nstop++;
    end
    check("released_to_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [11:0] op, ac;
    logic        clr;
    logic [11:0] data;
    logic        skp;
    int          period;
    logic [11:0] exp_ac;
    logic        exp_skip;
    int          exp_k, exp_start, exp_stop;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [11:0] r_ac, op, ac, data, exp_op;
    logic        r_skip, clr, skp;
    int          k, ncs, nstart, nstop, nstop_cs, acks, base, j;

    vecs[0] = '{12'o6771, 12'o1234, 1'b0, 12'o0000, 1'b1, 1, 12'o1234, 1'b1, 6, 1, 2};
    vecs[1] = '{12'o6532, 12'o7777, 1'b1, 12'o0123, 1'b0, 1, 12'o0123, 1'b0, 6, 1, 2};
    vecs[2] = '{12'o6031, 12'o0000, 1'b0, 12'o0055, 1'b1, 1, 12'o0055, 1'b1, 6, 1, 2};
    vecs[3] = '{12'o6046, 12'o1200, 1'b0, 12'o0034, 1'b0, 1, 12'o1234, 1'b0, 6, 1, 2};
    vecs[4] = '{12'o6771, 12'o4320, 1'b0, 12'o0001, 1'b0, 5, 12'o4321, 1'b0, 25, 4, 9};
    vecs[5] = '{12'o6101, 12'o7070, 1'b1, 12'o0000, 1'b1, 1, 12'o0000, 1'b1, 6, 1, 2};

    RESET = 1'b1; CSTEP = 1'b1; req = 1'b0; opcode = 12'o0000; ac_in = 12'o0000;
    repeat (3) tick();
    RESET = 1'b0;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({iopstart, iopstop}), 32'd0);
    check("rst_ac_out", 32'(ac_out), 32'd0);
    check("rst_skip_timeout", 32'({skip, timeout}), 32'd0);
    check("rst_latches", 32'({ioopcode, cputodev}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].op, vecs[i].ac, vecs[i].clr, vecs[i].data, vecs[i].skp,
              vecs[i].period, r_ac, r_skip, k, ncs, nstart, nstop, nstop_cs);
      check($sformatf("vec%0d_ac_out", i), 32'(r_ac), 32'(vecs[i].exp_ac));
      check($sformatf("vec%0d_skip", i), 32'(r_skip), 32'(vecs[i].exp_skip));
      check($sformatf("vec%0d_ack_cycle", i), 32'(k), 32'(vecs[i].exp_k));
      check($sformatf("vec%0d_start_cycles", i), 32'(nstart), 32'(vecs[i].exp_start));
      check($sformatf("vec%0d_stop_cycles", i), 32'(nstop), 32'(vecs[i].exp_stop));
      check($sformatf("vec%0d_cstep_to_ack", i), 32'(ncs), 32'(SETTLE + 1));
      check($sformatf("vec%0d_dev_saw_ac", i), 32'(seen_ac), 32'(vecs[i].ac));
      check($sformatf("vec%0d_dev_saw_op", i), 32'(seen_op), 32'(vecs[i].op));
      check($sformatf("vec%0d_no_timeout", i), 32'(timeout), 32'd0);
    end

    // Random transactions under random CSTEP gating against the merge rule.
    for (int i = 0; i < 20; i++) begin
      op = 12'($urandom); ac = 12'($urandom); data = 12'($urandom);
      clr = 1'($urandom); skp = 1'($urandom);
      if (i % 4 == 0) data = 12'o0000;
      run_txn(op, ac, clr, data, skp, 0, r_ac, r_skip, k, ncs, nstart, nstop, nstop_cs);
      check($sformatf("rnd%0d_ac_out", i), 32'(r_ac), 32'((clr ? 12'o0000 : ac) | data));
      check($sformatf("rnd%0d_skip", i), 32'(r_skip), 32'(skp));
      check($sformatf("rnd%0d_cstep_to_ack", i), 32'(ncs), 32'(SETTLE + 1));
      check($sformatf("rnd%0d_dev_saw_ac", i), 32'(seen_ac), 32'(ac));
      check($sformatf("rnd%0d_timeout", i), 32'(timeout), 32'd0);
    end

    // Stuck responder: release timeout after RELTMO+1 CSTEP cycles in STOP.
    stuck = 1'b1;
    run_txn(12'o6771, 12'o0100, 1'b0, 12'o0000, 1'b0, 1, r_ac, r_skip, k, ncs, nstart,
            nstop, nstop_cs);
    check("stuck_ac_out", 32'(r_ac), 32'(12'o0101));
    check("stuck_stop_csteps", 32'(nstop_cs), 32'(RELTMO + 1));
    check("stuck_timeout_set", 32'(timeout), 32'd1);
    stuck = 1'b0;
    repeat (3) tick();
    check("timeout_sticky", 32'({timeout, busy}), 32'b10);
    run_txn(12'o6772, 12'o0007, 1'b0, 12'o0000, 1'b1, 1, r_ac, r_skip, k, ncs, nstart,
            nstop, nstop_cs);
    check("timeout_cleared", 32'(timeout), 32'd0);
    check("after_timeout_ac", 32'(r_ac), 32'(12'o0007));

    // RESET while in WAIT aborts without ack; next transaction is normal.
    cfg_clr = 1'b0; cfg_data = 12'o0040; cfg_skp = 1'b1;
    opcode = 12'o6201; ac_in = 12'o0002; req = 1'b1; CSTEP = 1'b1;
    repeat (3) tick();
    check("in_wait", 32'({busy, iopstart, iopstop, ack}), 32'b1000);
    base = ack_count;
    RESET = 1'b1; req = 1'b0;
    tick();
    RESET = 1'b0;
    check("reset_abort", 32'({busy, iopstart, iopstop, ack}), 32'd0);
    repeat (20) tick();
    check("no_ack_after_reset", 32'(ack_count - base), 32'd0);
    run_txn(12'o6202, 12'o0300, 1'b0, 12'o0040, 1'b1, 1, r_ac, r_skip, k, ncs, nstart,
            nstop, nstop_cs);
    check("post_reset_ac", 32'(r_ac), 32'(12'o0340));
    check("post_reset_skip_k", 32'({r_skip, 8'(k)}), 32'({1'b1, 8'(SETTLE + 2)}));

    // req held high: three back-to-back transactions, ioopcode changes only on accept.
    cfg_clr = 1'b0; cfg_data = 12'o0000; cfg_skp = 1'b1;
    CSTEP = 1'b1; req = 1'b1; acks = 0; base = ack_count; exp_op = last_op; j = 0;
    while (acks < 3 && j < 200) begin
      opcode = 12'($urandom);
      if (!busy && req) exp_op = opcode;
      tick(); j++;
      check("ioopcode_hold", 32'(ioopcode), 32'(exp_op));
      if (ack) acks++;
      if (acks == 3) req = 1'b0;
    end
    req = 1'b0;
    repeat (30) tick();
    check("b2b_ack_pulses", 32'(ack_count - base), 32'd3);
    check("b2b_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pdp8l_iot_master.md
# pdp8l_iot_master

IOT bus initiator for the PDP-8/L FPGA design. Accepts one IOT transaction at a time from the CPU-side sequencer: opcode plus AC. Runs the device-side IOP handshake that the peripheral interfaces respond to: iopstart, settle, sample, iopstop until release. Returns the merged AC result and skip flag to the requester. Sits between the CPU IOT decode and the OR-combined device response bus.

## Interface
Parameters:
- SETTLE, 4, number of CSTEP cycles between the start strobe and response sampling (1..15)
- RELTMO, 255, max CSTEP cycles spent in STOP waiting for devices to release the bus (1..255)

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CSTEP  in  1  clock enable; device responders act only on CSTEP cycles
- req  in  1  transaction request (level)
- opcode  in  12  IOT instruction word
- ac_in  in  12  accumulator value sent with the IOT
- ack  out  1  one-cycle pulse; ac_out/skip valid this cycle
- ac_out  out  12  resulting AC
- skip  out  1  device requested skip
- busy  out  1  transaction in progress (state != IDLE)
- timeout  out  1  sticky: devices failed to release bus
- iopstart  out  1  IOP start strobe to devices
- iopstop  out  1  IOP release strobe to devices
- ioopcode  out  12  latched opcode to devices
- cputodev  out  12  latched AC to devices
- devtocpu  in  12  OR of device data returns
- AC_CLEAR  in  1  OR of device AC-clear requests
- IO_SKIP  in  1  OR of device skip requests

## Operation
- States: IDLE, START, WAIT, DONE, STOP.
- IDLE: if req=1, latch ioopcode<=opcode and cputodev<=ac_in, clear timeout, go to START.
- START: iopstart=1. On the first cycle with CSTEP=1, load cnt<=SETTLE-1 and go to WAIT. iopstart drops on leaving START.
- WAIT: on each CSTEP cycle, if cnt=0, capture the response and go to DONE; otherwise cnt<=cnt-1. Capture rule:
  - ac_out <= (AC_CLEAR ? 12'o0000 : cputodev) | devtocpu
  - skip <= IO_SKIP
- DONE: ack=1 for exactly one cycle, then go to STOP. Load tmo<=RELTMO.
- STOP: iopstop=1. On a CSTEP cycle:
  - If devtocpu==0, AC_CLEAR==0 and IO_SKIP==0, go to IDLE.
  - Else if tmo=0, set timeout=1 and go to IDLE.
  - Else tmo<=tmo-1.
- ac_out and skip hold their values until the next capture.
- ioopcode and cputodev hold until the next IDLE accept.
- Handshake rules:
  - The requester holds req until it sees ack, then drops it.
  - req is examined only in IDLE.
  - A req that stays high causes back-to-back transactions, one ack each.
- iopstart and iopstop are never both 1. Neither is 1 in IDLE or DONE.

## Timing
- Reset values: all outputs 0, state IDLE, cnt=0, tmo=0.
- RESET mid-transaction: state goes to IDLE on the next edge, all strobes 0, no ack. Devices are cleared by their own BINIT.
- Accept latency: req high in IDLE gives iopstart=1 on the next cycle.
- With CSTEP tied high:
  - START lasts 1 cycle.
  - WAIT lasts SETTLE cycles.
  - ack occurs SETTLE+2 cycles after the accept edge.
  - STOP lasts at least 1 cycle; devices clear on the iopstop CSTEP cycle, so zeros are seen on the following CSTEP cycle, typically 2 cycles.
- CSTEP low freezes START, WAIT and STOP (counters hold). DONE does not wait for CSTEP.
- Timeout fires on the (RELTMO+1)-th CSTEP cycle in STOP with a non-zero response. timeout stays 1 until RESET or the next accepted req.
- Minimum request-to-request period with CSTEP high: SETTLE+4 cycles.

## Test plan
- Skip (opcode 6771): responder model raises IO_SKIP one CSTEP after iopstart; ac_in=0o1234 -> ack with skip=1, ac_out=0o1234, ack at cycle 6 after accept (SETTLE=4), IDLE 2 cycles later.
- AC clear plus data: responder asserts AC_CLEAR and devtocpu=0o0123; ac_in=0o7777 -> ac_out=0o0123, skip=0. The responder sees cputodev=0o7777 and ioopcode=opcode during iopstart.
- CSTEP gating: CSTEP pulses once every 5 cycles. iopstart stays high until the first CSTEP cycle. ack arrives after exactly SETTLE further CSTEP cycles. Counters do not move on non-CSTEP cycles.
- Stuck responder: devtocpu held at 0o0001 forever. iopstop stays high for RELTMO+1 CSTEP cycles, then timeout=1, busy=0. The next req clears timeout.
- RESET asserted during WAIT: next cycle busy=0, iopstart=iopstop=0, no ack ever pulses. A subsequent req completes normally.
- req held high across 3 transactions: exactly 3 ack pulses. iopstart is never asserted while iopstop=1. ioopcode updates only in IDLE.
